// File: rtl/alu_inst_issue_queue.sv
// alu_inst_issue_queue
//
// Instruction-issue front end for the 4-register pipelined ALU. Instructions
// from a producer are buffered in a DEPTH-entry FIFO and issued at most one
// per cycle under start/pause/flush control. Any cycle without an issue
// drives a NOP bubble (8'h00). The ALU forwards fully, so no hazard stalls
// are generated here.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         asynchronous, active-high reset
//   in_valid    producer has an instruction on in_inst
//   in_inst     instruction {op[7:6], rs1[5:4], rs2[3:2], rd[1:0]}
//   in_ready    queue accepts in_inst this cycle
//   start       enter/resume issuing
//   pause       suspend issuing, FIFO contents kept
//   flush       discard FIFO contents, return to IDLE
//   inst        registered instruction to the ALU, 8'h00 = NOP
//   inst_valid  inst carries a dequeued instruction (not a bubble)
//   fifo_count  current occupancy, 0..DEPTH
//   issued_cnt  count of issued instructions with op != 2'b00 (wraps)
//   state       FSM state: 00 IDLE, 01 RUN, 10 PAUSED

module alu_inst_issue_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [7:0]               in_inst,
    output logic                     in_ready,
    input  logic                     start,
    input  logic                     pause,
    input  logic                     flush,
    output logic [7:0]               inst,
    output logic                     inst_valid,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         issued_cnt,
    output logic [1:0]               state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10
    } state_t;

    state_t             state_q;
    state_t             state_nxt;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [7:0]         mem [DEPTH];
    logic               push;
    logic               pop;
    logic [7:0]         head;

    assign state = state_q;
    assign head  = mem[rd_ptr];

    // Registered count plus the live flush input; a flush cycle drops pushes.
    assign in_ready = (fifo_count < CW'(DEPTH)) && !flush;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // FSM next-state logic; flush overrides every other request.
    always_comb begin
        state_nxt = state_q;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start)           state_nxt = RUN;
                RUN:     if (pause)           state_nxt = PAUSED;
                PAUSED:  if (start && !pause) state_nxt = RUN;
                default:                      state_nxt = IDLE;
            endcase
        end
    end

    // FSM outputs: FIFO push/pop decode. A pop needs a non-empty FIFO at the
    // start of the cycle, so a same-cycle push can never bypass to inst.
    always_comb begin
        push = in_valid && in_ready;
        pop  = (state_q == RUN) && (fifo_count != '0) && !pause && !flush;
    end

    // FIFO storage; contents are don't-care after reset/flush, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_inst;
        end
    end

    // Pointers, occupancy and the registered issue slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            inst       <= 8'h00;
            inst_valid <= 1'b0;
            issued_cnt <= '0;
        end else if (flush) begin
            // issued_cnt deliberately survives a flush.
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            inst       <= 8'h00;
            inst_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (pop) begin
                inst       <= head;
                inst_valid <= 1'b1;
                if (head[7:6] != 2'b00) begin
                    issued_cnt <= issued_cnt + CNT_W'(1);
                end
            end else begin
                inst       <= 8'h00;
                inst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_inst_issue_queue.sv
// tb_alu_inst_issue_queue
//
// Bench for alu_inst_issue_queue (DEPTH=8, CNT_W=4 so counter wrap is
// reachable quickly). A negedge monitor keeps a scoreboard queue of accepted
// instructions plus a small reference FSM, and compares every DUT output
// each cycle; directed checks cover the scenario-specific values.

module tb_alu_inst_issue_queue;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_RUN    = 2'b01;
    localparam logic [1:0] S_PAUSED = 2'b10;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic [7:0]             in_inst = 8'h00;
    logic                   in_ready;
    logic                   start = 1'b0;
    logic                   pause = 1'b0;
    logic                   flush = 1'b0;
    logic [7:0]             inst;
    logic                   inst_valid;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [CNT_W-1:0]       issued_cnt;
    logic [1:0]             state;

    alu_inst_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_inst    (in_inst),
        .in_ready   (in_ready),
        .start      (start),
        .pause      (pause),
        .flush      (flush),
        .inst       (inst),
        .inst_valid (inst_valid),
        .fifo_count (fifo_count),
        .issued_cnt (issued_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0]       sb[$];
    logic [1:0]       mstate = S_IDLE;
    logic             exp_valid = 1'b0;
    logic [CNT_W-1:0] mcnt = '0;
    int               n_out = 0;
    logic [7:0]       e;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            mstate    = S_IDLE;
            exp_valid = 1'b0;
            mcnt      = '0;
        end else begin
            chk("inst_valid", 32'(inst_valid), 32'(exp_valid));
            if (inst_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    n_out++;
                    chk("inst", 32'(inst), 32'(e));
                    if (e[7:6] != 2'b00) mcnt = mcnt + 1'b1;
                end
            end else begin
                chk("bubble", 32'(inst), 32'h0);
            end
            chk("fifo_count", 32'(fifo_count), 32'(sb.size()));
            chk("state", 32'(state), 32'(mstate));
            chk("issued_cnt", 32'(issued_cnt), 32'(mcnt));
            chk("in_ready", 32'(in_ready), 32'((sb.size() < DEPTH) && !flush));
            // Predict the next rising edge
            if (flush) begin
                sb.delete();
                exp_valid = 1'b0;
                mstate    = S_IDLE;
            end else begin
                exp_valid = (mstate == S_RUN) && (sb.size() != 0) && !pause;
                if (in_valid && sb.size() < DEPTH) sb.push_back(in_inst);
                case (mstate)
                    S_IDLE:   if (start)           mstate = S_RUN;
                    S_RUN:    if (pause)           mstate = S_PAUSED;
                    S_PAUSED: if (start && !pause) mstate = S_RUN;
                    default:                       mstate = S_IDLE;
                endcase
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [7:0] d);
        in_valid = 1'b1;
        in_inst  = d;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
    endtask

    logic [CNT_W-1:0] snap;
    int               out_snap;

    initial begin
        // Reset values
        repeat (2) cyc();
        chk("rst_inst", 32'(inst), 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_count", 32'(fifo_count), 32'h0);
        chk("rst_issued", 32'(issued_cnt), 32'h0);
        rst = 1'b0;
        cyc();
        chk("rst_ready", 32'(in_ready), 32'h1);

        // Basic fill in IDLE then issue
        push_one(8'h41);
        push_one(8'h86);
        push_one(8'hC7);
        chk("idle_count", 32'(fifo_count), 32'd3);
        chk("idle_inst", 32'(inst), 32'h0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("start_state", 32'(state), 32'(S_RUN));
        chk("start_inst", 32'(inst), 32'h0);
        cyc(); chk("issue0", 32'(inst), 32'h41);
        cyc(); chk("issue1", 32'(inst), 32'h86);
        cyc(); chk("issue2", 32'(inst), 32'hC7);
        cyc(); chk("issue_end", 32'({inst_valid, inst}), 32'h0);
        chk("issued3", 32'(issued_cnt), 32'd3);

        // Fill to full, reject the 9th, then run with continuous pushes
        do_flush();
        chk("flush_idle", 32'(state), 32'(S_IDLE));
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_inst  = 8'h50 + 8'(i);
            if (i == 8) chk("full_ready", 32'(in_ready), 32'h0);
            cyc();
        end
        chk("full_count", 32'(fifo_count), 32'd8);
        in_inst = 8'hE0;
        start   = 1'b1;
        cyc();
        start = 1'b0;
        for (int j = 1; j < 7; j++) begin
            in_inst = 8'hE0 + 8'(j);
            cyc();
        end
        chk("steady_count", 32'(fifo_count), 32'd7);
        in_valid = 1'b0;
        repeat (10) cyc();
        chk("drain_count", 32'(fifo_count), 32'd0);

        // Pause after the second issue, then resume
        do_flush();
        for (int i = 0; i < 4; i++) push_one(8'h61 + 8'(i));
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc(); chk("pre_pause", 32'(inst), 32'h62);
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        chk("pause_inst", 32'(inst), 32'h0);
        chk("pause_state", 32'(state), 32'(S_PAUSED));
        chk("pause_count", 32'(fifo_count), 32'd2);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("resume_state", 32'(state), 32'(S_RUN));
        chk("resume_gap", 32'(inst_valid), 32'h0);
        cyc(); chk("resume0", 32'(inst), 32'h63);
        cyc(); chk("resume1", 32'(inst), 32'h64);

        // Flush together with start and in_valid while RUN with 5 queued
        do_flush();
        for (int i = 0; i < 5; i++) push_one(8'h81 + 8'(i));
        start = 1'b1;
        cyc();
        snap     = mcnt;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_inst  = 8'hAA;
        cyc();
        flush    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        chk("fl_state", 32'(state), 32'(S_IDLE));
        chk("fl_count", 32'(fifo_count), 32'd0);
        chk("fl_inst", 32'({inst_valid, inst}), 32'h0);
        chk("fl_issued", 32'(issued_cnt), 32'(snap));

        // NOPs still issue with inst_valid but do not count
        push_one(8'h00);
        push_one(8'h41);
        push_one(8'h00);
        snap  = mcnt;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (4) cyc();
        chk("nop_issued", 32'(issued_cnt), 32'(snap + 1'b1));

        // Counter wrap: 17 non-NOP issues from zero
        rst = 1'b1;
        cyc();
        rst   = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 17; i++) push_one(8'h40 + 8'(i));
        repeat (4) cyc();
        chk("cnt_wrap", 32'(issued_cnt), 32'd1);

        // Pointer wrap: 20 back-to-back random entries
        out_snap = n_out;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_inst = 8'($urandom);
            cyc();
        end
        in_valid = 1'b0;
        repeat (4) cyc();
        chk("wrap_count", 32'(fifo_count), 32'd0);
        chk("wrap_outputs", 32'(n_out - out_snap), 32'd20);

        // Asynchronous reset mid-stream
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_inst = 8'hC0 + 8'(i);
            cyc();
        end
        #2;
        rst = 1'b1;
        #1;
        chk("arst_inst", 32'(inst), 32'h0);
        chk("arst_valid", 32'(inst_valid), 32'h0);
        chk("arst_state", 32'(state), 32'(S_IDLE));
        chk("arst_count", 32'(fifo_count), 32'h0);
        in_valid = 1'b0;
        cyc();
        rst = 1'b0;
        repeat (3) cyc();
        chk("post_state", 32'(state), 32'(S_IDLE));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
